// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, key codes,
// keymap lookup and one-cold column drive.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Physical key position to 4-bit key code.
    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs (keypad rows, buttons).
module sync_2ff #(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with row synchronisation, debounce and key decode.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DLY   = 100,
    parameter int unsigned REPEAT_PER   = 25
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT + 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_DLY + REPEAT_PER + 1);
`endif

    logic [3:0]       rows;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             single;
    logic             idle;
    logic [1:0]       sample_row;
    logic [1:0]       col_idx;
    logic [1:0]       col_next;
    logic [1:0]       lat_row;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] rel_cnt;
    state_t           state;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [REP_W-1:0] rep_cnt;
`endif

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (rows)
    );

    // Dwell divider; the last cycle of each dwell is the sample tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick     = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign idle     = (rows == 4'b1111);
    assign col_next = col_idx + 2'd1;

    always_comb begin
        single     = 1'b1;
        sample_row = 2'd0;
        case (rows)
            4'b1110: sample_row = 2'd0;
            4'b1101: sample_row = 2'd1;
            4'b1011: sample_row = 2'd2;
            4'b0111: sample_row = 2'd3;
            default: single     = 1'b0;
        endcase
    end

    // Scan / debounce / hold FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            col_out   <= 4'b1110;
            lat_row   <= 2'd0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (single) begin
                            lat_row <= sample_row;
                            deb_cnt <= DEB_W'(1);
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_next;
                            col_out <= col_drive(col_next);
                        end
                    end
                    DEBOUNCE: begin
                        if (single && sample_row == lat_row) begin
                            if (deb_cnt == DEB_W'(DEBOUNCE_CNT - 1)) begin
                                key_code  <= keymap(lat_row, col_idx);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= '0;
                                rel_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= deb_cnt + DEB_W'(1);
                            end
                        end else begin
                            deb_cnt <= '0;
                            state   <= SCAN;
                            col_idx <= col_next;
                            col_out <= col_drive(col_next);
                        end
                    end
                    HELD: begin
                        if (idle) begin
                            if (rel_cnt == DEB_W'(DEBOUNCE_CNT - 1)) begin
                                key_held <= 1'b0;
                                rel_cnt  <= '0;
                                state    <= SCAN;
                                col_idx  <= col_next;
                                col_out  <= col_drive(col_next);
                            end else begin
                                rel_cnt <= rel_cnt + DEB_W'(1);
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        // First repeat at REPEAT_DLY, then fold back to keep a REPEAT_PER period.
                        if (single && sample_row == lat_row) begin
                            if (rep_cnt == REP_W'(REPEAT_DLY + REPEAT_PER - 1)) begin
                                key_valid <= 1'b1;
                                rep_cnt   <= REP_W'(REPEAT_DLY);
                            end else begin
                                if (rep_cnt == REP_W'(REPEAT_DLY - 1)) begin
                                    key_valid <= 1'b1;
                                end
                                rep_cnt <= rep_cnt + REP_W'(1);
                            end
                        end else begin
                            rep_cnt <= '0;
                        end
`endif
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule
